swm_tx_lane_packer: RTL and testbench
=====================================

Name: swm_tx_lane_packer

Overview:
Multi-lane successor to the single-lane SerialLite III TX adapter. It accepts 32-bit Avalon-ST packets and packs 2*LANES consecutive words into one LANES*64-bit beat, padding partial beats with the 0xBCBCBCBC word-alignment pattern. Packed beats are buffered in a FIFO so the sink sees a stable ready. It adds burst framing, sticky error capture and packet/drop counters. It sits between the packet source and the SL3 IP TX user interface.

Parameters:
LANES, 4, number of 64-bit lanes; PACK = 2*LANES sink words per beat.
FIFO_DEPTH, 8, beats buffered (power of 2, >=2).
SYNC_VALUE, 8'd4, constant driven on sync_tx.
PAD_WORD, 32'hBCBCBCBC, fill for unused 32-bit slots.

Ports:
clk_in_clk  in  1  single clock
reset_in_rst_n  in  1  asynchronous active-low reset
avalonst_sink_data  in  32  sink word
avalonst_sink_valid  in  1  sink valid
avalonst_sink_startofpacket  in  1  first word of packet
avalonst_sink_endofpacket  in  1  last word of packet
avalonst_sink_ready  out  1  sink ready
data_tx  out  LANES*64  packed beat; slot k = bits [32k+31:32k]
valid_tx  out  1  beat valid
start_of_burst_tx  out  1  first beat of packet
end_of_burst_tx  out  1  last beat of packet
error_tx  in  4  IP error flags
sync_tx  out  8  constant SYNC_VALUE
ready_tx  in  1  IP ready
err_clear  in  1  clears err_sticky and proto_err
err_sticky  out  4  OR-accumulated error_tx
proto_err  out  1  sticky: SOP seen while in packet
pkt_count  out  32  packets completed (EOB beats pushed), wraps
drop_count  out  16  words dropped outside a packet, saturates at 16'hFFFF

Behaviour:
- Reset: FIFO empty, state IDLE, slot index 0, all counters/stickies 0. valid_tx, SOB, EOB = 0; data_tx = 0. sink_ready = 1 after reset (FIFO empty).
- Accept = sink_valid && sink_ready. sink_ready = (fifo_count < FIFO_DEPTH), registered count only, with no combinational path from sink_valid or ready_tx.
- FSM IDLE: accepted word with SOP -> write slot 0 (idx=1), mark pending SOB, go IN_PKT. Accepted word without SOP -> dropped, drop_count++ (saturating).
- FSM IN_PKT: accepted word writes slot idx.
  - If idx==PACK-1 or EOP: push beat {accumulator, word, PAD_WORD in remaining slots}. SOB = pending flag, which then clears. EOB = EOP. Reset idx to 0.
  - On EOP: pkt_count++, go IDLE.
- SOP+EOP single word: one beat, slot 0 = data, other slots = PAD_WORD, SOB=EOB=1.
- SOP while IN_PKT: word accepted, proto_err set.
  - If idx>0: push padded partial beat with EOB=1.
  - If idx==0: push all-PAD beat, SOB=0, EOB=1.
  - pkt_count++ in both cases. The new word goes to slot 0 with pending SOB; state stays IN_PKT.
- At most one push per cycle.
- FIFO: FWFT. Pushed beat is visible on data_tx/valid_tx the cycle after the push edge (latency 1 from the completing accept). Pop = valid_tx && ready_tx. Push and pop in the same cycle leave the count unchanged. Full -> no accept. Empty -> valid_tx=0; data_tx holds its last value.
- Slots not written by an accepted word are always PAD_WORD, never stale data.
- err_sticky |= error_tx every cycle. err_clear zeroes err_sticky and proto_err; a same-cycle set wins.
- Reset asserted mid-packet: everything returns to reset values immediately; partial beat and FIFO contents are lost.

Decomposition:
- Package swm_tx_pkg: PAD_WORD, default SYNC_VALUE, state enum {IDLE, IN_PKT}, beat struct {data, sob, eob}.
- One sub-module swm_tx_beat_fifo: parameterised width/depth, FWFT, count output.

Test Plan:
- LANES=4, 8-word packet 1..8 with SOP/EOP -> one beat, slots 0..7 = 1..8, SOB=EOB=1; valid_tx 1 cycle after the 8th accept; pkt_count=1.
- LANES=4, 11-word packet -> beat0 words 1..8 (SOB=1, EOB=0); beat1 slots 0..2 = 9..11, slots 3..7 = BCBCBCBC, EOB=1.
- ready_tx=0 with 9 full beats offered -> sink_ready drops after the 8th beat push; no loss; release ready_tx -> 9 beats in order.
- 3 words without SOP in IDLE -> no beats, drop_count=3; then a valid packet packs normally.
- SOP at word 3 of an open packet -> padded beat (slots 0..1 data, EOB=1), proto_err=1, new packet SOB on the next beat; err_clear -> proto_err=0.
- error_tx=4'b0010 for 1 cycle -> err_sticky=0010 held; err_clear with error_tx=0100 same cycle -> err_sticky=0100.

Source files
------------

// File: rtl/swm_tx_pkg.sv
// Shared constants and types for the multi-lane SerialLite III TX packer.
package swm_tx_pkg;

   // Word-alignment fill for 32-bit slots that carry no packet data.
   localparam logic [31:0] PAD_WORD_DEFAULT   = 32'hBCBCBCBC;
   // Constant presented to the IP on sync_tx.
   localparam logic [7:0]  SYNC_VALUE_DEFAULT = 8'd4;

   // Packing state: waiting for a start-of-packet, or assembling a packet.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      IN_PKT = 1'b1
   } pkt_state_t;

   // Framing flags travelling with every packed beat.
   typedef struct packed {
      logic sob;
      logic eob;
   } beat_flags_t;

endpackage

// File: rtl/swm_tx_lane_packer_if.sv
// Avalon-ST sink plus SL3 TX user bus. The slave modport is the packer's view;
// the master modport is the view of whatever drives the source and models the IP.
interface swm_tx_lane_packer_if #(
   parameter int unsigned LANES = 4
);
   logic [31:0]         avalonst_sink_data;
   logic                avalonst_sink_valid;
   logic                avalonst_sink_startofpacket;
   logic                avalonst_sink_endofpacket;
   logic                avalonst_sink_ready;

   logic [LANES*64-1:0] data_tx;
   logic                valid_tx;
   logic                start_of_burst_tx;
   logic                end_of_burst_tx;
   logic [3:0]          error_tx;
   logic [7:0]          sync_tx;
   logic                ready_tx;

   modport slave (
      input  avalonst_sink_data, avalonst_sink_valid,
      input  avalonst_sink_startofpacket, avalonst_sink_endofpacket,
      output avalonst_sink_ready,
      output data_tx, valid_tx, start_of_burst_tx, end_of_burst_tx, sync_tx,
      input  error_tx, ready_tx
   );

   modport master (
      output avalonst_sink_data, avalonst_sink_valid,
      output avalonst_sink_startofpacket, avalonst_sink_endofpacket,
      input  avalonst_sink_ready,
      input  data_tx, valid_tx, start_of_burst_tx, end_of_burst_tx, sync_tx,
      output error_tx, ready_tx
   );

endinterface

// File: rtl/swm_tx_beat_fifo.sv
// First-word-fall-through FIFO. The head entry is visible the cycle after it is
// pushed. When empty, the output holds the last popped entry (zero after reset).
module swm_tx_beat_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8   // power of 2, >= 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] hold_q;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && (count_q != CW'(DEPTH));

   // Storage write; entries are only ever read after being written.
   // NOTE: the storage array has no reset so it maps onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Pointers, occupancy and the last-popped hold register.
   // NOTE: state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            hold_q   <= mem_q[rd_ptr_q];
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign rd_valid_o = (count_q != '0);
   assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : hold_q;
   assign count_o    = count_q;

endmodule

// File: rtl/swm_tx_lane_packer.sv
// Packs 32-bit Avalon-ST words, 2*LANES at a time, into LANES*64-bit SL3 beats
// with burst framing, buffers them in a FIFO, and tracks errors and counters.
module swm_tx_lane_packer
   import swm_tx_pkg::*;
#(
   parameter int unsigned LANES      = 4,   // must match the interface LANES
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [7:0]  SYNC_VALUE = SYNC_VALUE_DEFAULT,
   parameter logic [31:0] PAD_WORD   = PAD_WORD_DEFAULT
) (
   input  logic                        clk_in_clk,
   input  logic                        reset_in_rst_n,
   swm_tx_lane_packer_if.slave         bus,
   input  logic                        err_clear,
   output logic [3:0]                  err_sticky,
   output logic                        proto_err,
   output logic [31:0]                 pkt_count,
   output logic [15:0]                 drop_count
);

   localparam int unsigned PACK = 2 * LANES;
   localparam int unsigned DW   = LANES * 64;
   localparam int unsigned IW   = $clog2(PACK);
   localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DW-1:0] ALL_PAD = {PACK{PAD_WORD}};

   typedef struct packed {
      logic [DW-1:0] data;
      beat_flags_t   flags;
   } beat_t;

   pkt_state_t    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] acc_q, acc_d;       // unwritten slots always hold PAD_WORD
   logic          sob_pend_q, sob_pend_d;
   logic [31:0]   pkt_q;
   logic [15:0]   drop_q;
   logic [3:0]    err_q;
   logic          proto_q;

   logic          accept, sink_ready;
   logic          push, pop, pkt_inc, drop_inc, proto_set;
   beat_t         push_beat, head;
   logic          fifo_valid;
   logic [CW-1:0] fifo_count;
   logic [DW-1:0] merged, first;
   logic [31:0]   word;
   logic          sop, eop;

   assign word       = bus.avalonst_sink_data;
   assign sop        = bus.avalonst_sink_startofpacket;
   assign eop        = bus.avalonst_sink_endofpacket;
   // Ready depends only on registered occupancy, never on valid or ready_tx.
   assign sink_ready = (fifo_count < CW'(FIFO_DEPTH));
   assign accept     = bus.avalonst_sink_valid && sink_ready;
   assign pop        = fifo_valid && bus.ready_tx;

   // Packing FSM: decide slot writes, beat pushes and counter events.
   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      acc_d            = acc_q;
      sob_pend_d       = sob_pend_q;
      push             = 1'b0;
      push_beat.data   = acc_q;
      push_beat.flags  = '{sob: sob_pend_q, eob: 1'b0};
      pkt_inc          = 1'b0;
      drop_inc         = 1'b0;
      proto_set        = 1'b0;
      merged           = acc_q;
      merged[{idx_q, 5'b0} +: 32] = word;
      first            = ALL_PAD;
      first[31:0]      = word;

      if (accept) begin
         case (state_q)
            IDLE: begin
               if (!sop) begin
                  drop_inc = 1'b1;
               end else if (eop) begin
                  // Single-word packet: one fully framed beat, stay idle.
                  push            = 1'b1;
                  push_beat.data  = first;
                  push_beat.flags = '{sob: 1'b1, eob: 1'b1};
                  pkt_inc         = 1'b1;
               end else begin
                  acc_d      = first;
                  idx_d      = IW'(1);
                  sob_pend_d = 1'b1;
                  state_d    = IN_PKT;
               end
            end
            IN_PKT: begin
               if (sop) begin
                  // Restart inside an open packet: close it with what is
                  // buffered (all PAD if nothing), then open the new one.
                  // An EOP on this restarting word is not honoured.
                  push            = 1'b1;
                  push_beat.data  = acc_q;
                  push_beat.flags = '{sob: sob_pend_q, eob: 1'b1};
                  pkt_inc         = 1'b1;
                  proto_set       = 1'b1;
                  acc_d           = first;
                  idx_d           = IW'(1);
                  sob_pend_d      = 1'b1;
               end else if (idx_q == IW'(PACK - 1) || eop) begin
                  push            = 1'b1;
                  push_beat.data  = merged;
                  push_beat.flags = '{sob: sob_pend_q, eob: eop};
                  acc_d           = ALL_PAD;
                  idx_d           = '0;
                  sob_pend_d      = 1'b0;
                  if (eop) begin
                     pkt_inc = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  acc_d = merged;
                  idx_d = idx_q + IW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM, accumulator, counters and sticky flags.
   always_ff @(posedge clk_in_clk or negedge reset_in_rst_n) begin
      if (!reset_in_rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         acc_q      <= ALL_PAD;
         sob_pend_q <= 1'b0;
         pkt_q      <= '0;
         drop_q     <= '0;
         err_q      <= '0;
         proto_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         sob_pend_q <= sob_pend_d;
         if (pkt_inc) pkt_q <= pkt_q + 32'd1;
         if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         // A set arriving in the same cycle as a clear survives the clear.
         err_q   <= err_clear ? bus.error_tx : (err_q | bus.error_tx);
         proto_q <= err_clear ? proto_set    : (proto_q | proto_set);
      end
   end

   swm_tx_beat_fifo #(
      .WIDTH ($bits(beat_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk_in_clk),
      .rst_n      (reset_in_rst_n),
      .push_i     (push),
      .wr_data_i  (push_beat),
      .pop_i      (pop),
      .rd_data_o  (head),
      .rd_valid_o (fifo_valid),
      .count_o    (fifo_count)
   );

   assign bus.avalonst_sink_ready = sink_ready;
   assign bus.data_tx             = head.data;
   assign bus.valid_tx            = fifo_valid;
   assign bus.start_of_burst_tx   = fifo_valid && head.flags.sob;
   assign bus.end_of_burst_tx     = fifo_valid && head.flags.eob;
   assign bus.sync_tx             = SYNC_VALUE;

   assign err_sticky = err_q;
   assign proto_err  = proto_q;
   assign pkt_count  = pkt_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_swm_tx_lane_packer.sv
// Scoreboard bench: a packet-level model fills an expected-beat queue when
// words are accepted; a monitor pops and compares every beat the IP takes.
module tb_swm_tx_lane_packer;

   localparam int unsigned LANES = 4;
   localparam int unsigned PACK  = 2 * LANES;
   localparam int unsigned DW    = LANES * 64;
   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] PAD   = 32'hBCBCBCBC;

   logic        clk_in_clk = 1'b0;
   logic        reset_in_rst_n = 1'b0;
   logic        err_clear = 1'b0;
   logic [3:0]  err_sticky;
   logic        proto_err;
   logic [31:0] pkt_count;
   logic [15:0] drop_count;

   swm_tx_lane_packer_if #(.LANES(LANES)) bus ();

   swm_tx_lane_packer #(
      .LANES      (LANES),
      .FIFO_DEPTH (DEPTH),
      .SYNC_VALUE (8'd4),
      .PAD_WORD   (PAD)
   ) dut (
      .clk_in_clk     (clk_in_clk),
      .reset_in_rst_n (reset_in_rst_n),
      .bus            (bus),
      .err_clear      (err_clear),
      .err_sticky     (err_sticky),
      .proto_err      (proto_err),
      .pkt_count      (pkt_count),
      .drop_count     (drop_count)
   );

   always #5 clk_in_clk = ~clk_in_clk;

   typedef struct {
      logic [DW-1:0] data;
      bit            sob;
      bit            eob;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_words[$];
   bit          m_in_pkt, m_sob_pend, m_proto;
   int          m_pkts, m_drops;
   logic [3:0]  m_err;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string msg);
      n_checks++;
      $display("FAIL %s", msg);
   endtask

   // Close the words gathered so far into one expected beat, padded to PACK slots.
   task automatic emit(input bit sob, input bit eob);
      exp_t e;
      for (int k = 0; k < PACK; k++)
         e.data[k*32 +: 32] = (k < m_words.size()) ? m_words[k] : PAD;
      e.sob = sob;
      e.eob = eob;
      sb.push_back(e);
      if (eob) m_pkts++;
      m_words.delete();
   endtask

   // Packet-level reference: what happens to one accepted word.
   task automatic model_accept(input logic [31:0] d, input bit sop, input bit eop, output bit proto_hit);
      proto_hit = 1'b0;
      if (!m_in_pkt && !sop) begin
         if (m_drops != 65535) m_drops++;
         return;
      end
      if (m_in_pkt && sop) begin
         proto_hit = 1'b1;
         emit(m_sob_pend, 1'b1);
      end
      if (sop) begin
         m_in_pkt   = 1'b1;
         m_sob_pend = 1'b1;
      end
      m_words.push_back(d);
      if (eop || m_words.size() == PACK) begin
         emit(m_sob_pend, eop);
         m_sob_pend = 1'b0;
         if (eop) m_in_pkt = 1'b0;
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_words.delete();
      m_in_pkt = 0; m_sob_pend = 0; m_proto = 0;
      m_pkts = 0; m_drops = 0; m_err = '0;
   endtask

   // One clock: drive inputs, update the model, step past the edge, check sidebands.
   task automatic drive_cycle(input bit v, input logic [31:0] d, input bit sop, input bit eop,
                              input bit rdy, input logic [3:0] err, input bit clr, output bit accepted);
      bit hit;
      bus.avalonst_sink_valid         = v;
      bus.avalonst_sink_data          = d;
      bus.avalonst_sink_startofpacket = sop;
      bus.avalonst_sink_endofpacket   = eop;
      bus.ready_tx                    = rdy;
      bus.error_tx                    = err;
      err_clear                       = clr;
      accepted = v && bus.avalonst_sink_ready;
      hit = 1'b0;
      if (accepted) model_accept(d, sop, eop, hit);
      m_err   = clr ? err : (m_err | err);
      m_proto = clr ? hit : (m_proto | hit);
      @(posedge clk_in_clk);
      #1;
      check("pkt_count",  pkt_count,  m_pkts);
      check("drop_count", drop_count, m_drops);
      check("err_sticky", err_sticky, m_err);
      check("proto_err",  proto_err,  m_proto);
   endtask

   task automatic send_word(input logic [31:0] d, input bit sop, input bit eop, input bit rdy);
      bit ok;
      for (int t = 0; t < 64; t++) begin
         drive_cycle(1'b1, d, sop, eop, rdy, 4'b0, 1'b0, ok);
         if (ok) return;
      end
      fail_now($sformatf("accept_timeout word %0h", d));
   endtask

   task automatic idle(input int n, input bit rdy);
      bit ok;
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, rdy, 4'b0, 1'b0, ok);
   endtask

   task automatic check_reset_state();
      check("rst_valid_tx",   bus.valid_tx, 0);
      check("rst_data_tx",    bus.data_tx, 0);
      check("rst_sob",        bus.start_of_burst_tx, 0);
      check("rst_eob",        bus.end_of_burst_tx, 0);
      check("rst_sink_ready", bus.avalonst_sink_ready, 1);
      check("rst_pkt_count",  pkt_count, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_err_sticky", err_sticky, 0);
      check("rst_proto_err",  proto_err, 0);
      check("sync_tx",        bus.sync_tx, 8'd4);
   endtask

   // Monitor: every beat the IP takes must be the next expected one.
   always @(negedge clk_in_clk) begin
      if (reset_in_rst_n && bus.valid_tx && bus.ready_tx) begin
         if (sb.size() == 0) begin
            fail_now($sformatf("unexpected_beat data %0h", bus.data_tx));
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("beat_data", bus.data_tx, e.data);
            check("beat_sob",  bus.start_of_burst_tx, e.sob);
            check("beat_eob",  bus.end_of_burst_tx, e.eob);
         end
      end
   end

   initial begin
      bit ok;
      bus.avalonst_sink_valid = 0; bus.avalonst_sink_data = '0;
      bus.avalonst_sink_startofpacket = 0; bus.avalonst_sink_endofpacket = 0;
      bus.ready_tx = 0; bus.error_tx = '0;
      model_reset();
      @(posedge clk_in_clk); #1;
      check_reset_state();
      reset_in_rst_n = 1'b1;
      idle(1, 1'b0);

      // Full 8-word packet; beat appears exactly one cycle after the last accept.
      for (int i = 1; i <= 8; i++) begin
         send_word(32'(i), i == 1, i == 8, 1'b0);
         check("valid_latency", bus.valid_tx, (i == 8));
      end
      idle(3, 1'b1);

      // 11-word packet: one full beat, then a padded tail beat.
      for (int i = 1; i <= 11; i++) send_word(32'(i), i == 1, i == 11, 1'b1);
      idle(3, 1'b1);

      // Backpressure: eight full beats fill the FIFO, the ninth waits.
      for (int p = 0; p < 8; p++) begin
         for (int i = 0; i < 8; i++) send_word(32'h100 * (p + 1) + 32'(i), i == 0, i == 7, 1'b0);
         if (p == 6) check("ready_before_full", bus.avalonst_sink_ready, 1);
      end
      check("ready_when_full", bus.avalonst_sink_ready, 0);
      for (int t = 0; t < 3; t++) begin
         drive_cycle(1'b1, 32'h900, 1'b1, 1'b0, 1'b0, 4'b0, 1'b0, ok);
         check("no_accept_full", ok, 0);
      end
      for (int i = 0; i < 8; i++) send_word(32'h900 + 32'(i), i == 0, i == 7, 1'b1);
      idle(12, 1'b1);

      // Words outside a packet are dropped, then a normal packet.
      for (int i = 0; i < 3; i++) send_word(32'hD0 + 32'(i), 1'b0, 1'b0, 1'b1);
      check("drops_three", drop_count, 3);
      for (int i = 1; i <= 5; i++) send_word(32'hE0 + 32'(i), i == 1, i == 5, 1'b1);
      idle(3, 1'b1);

      // Restart at word 3 of an open packet.
      send_word(32'hA1, 1'b1, 1'b0, 1'b1);
      send_word(32'hA2, 1'b0, 1'b0, 1'b1);
      send_word(32'hA3, 1'b1, 1'b0, 1'b1);
      check("proto_set", proto_err, 1);
      send_word(32'hA4, 1'b0, 1'b0, 1'b1);
      send_word(32'hA5, 1'b0, 1'b1, 1'b1);
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0, 1'b1, ok);
      check("proto_clear", proto_err, 0);
      idle(2, 1'b1);

      // Sticky error capture and clear-with-set.
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, ok);
      idle(3, 1'b1);
      check("err_held", err_sticky, 4'b0010);
      drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b1, ok);
      check("err_clear_set", err_sticky, 4'b0100);

      // Reset in mid-packet discards everything; next packet shows no stale slots.
      for (int i = 1; i <= 3; i++) send_word(32'hC0 + 32'(i), i == 1, 1'b0, 1'b1);
      reset_in_rst_n = 1'b0;
      #1;
      check_reset_state();
      model_reset();
      @(posedge clk_in_clk); #1;
      reset_in_rst_n = 1'b1;
      send_word(32'hF1, 1'b1, 1'b0, 1'b1);
      send_word(32'hF2, 1'b0, 1'b1, 1'b1);
      idle(3, 1'b1);

      // Randomised traffic with random backpressure and error injection.
      for (int w = 0; w < 300; w++) begin
         logic [31:0] d;
         bit sop, eop, v, rdy, clr;
         logic [3:0] err;
         int tries;
         d   = $urandom;
         sop = m_in_pkt ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
         eop = ($urandom_range(0, 5) == 0);
         if (sop && m_in_pkt) eop = 1'b0;
         ok = 1'b0;
         tries = 0;
         while (!ok && tries < 100) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            err = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
            clr = ($urandom_range(0, 31) == 0);
            drive_cycle(v, d, sop, eop, rdy, err, clr, ok);
            tries++;
         end
         if (!ok) fail_now($sformatf("random_accept_timeout word %0d", w));
      end

      // Drain everything still expected.
      for (int t = 0; t < 200 && sb.size() != 0; t++) idle(1, 1'b1);
      if (sb.size() != 0) fail_now($sformatf("drain_timeout %0d beats missing", sb.size()));
      idle(2, 1'b1);
      check("drained_valid", bus.valid_tx, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
